// File: rtl/cacheline_burst_adapter.sv
// Cache-line to memory-burst adapter: splits one whole-line read or writeback
// into BURST_LEN beats on the memory bus, reassembling or serialising line data.
module cacheline_burst_adapter #(
   parameter int unsigned CACHE_LINE_WIDTH = 256,
   parameter int unsigned BURST_LEN        = 4,
   parameter int unsigned BURST_WIDTH      = CACHE_LINE_WIDTH / BURST_LEN
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        line_read,
   input  logic                        line_write,
   input  logic [31:0]                 line_addr,
   input  logic [CACHE_LINE_WIDTH-1:0] line_wdata,
   output logic [CACHE_LINE_WIDTH-1:0] line_rdata,
   output logic                        line_resp,
   output logic                        line_error,
   output logic                        busy,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic [31:0]                 mem_address,
   output logic [BURST_WIDTH-1:0]      mem_wdata,
   output logic [BURST_WIDTH/8-1:0]    mem_byte_enable,
   input  logic [BURST_WIDTH-1:0]      mem_rdata,
   input  logic                        mem_resp,
   input  logic                        pm_error
);

   localparam int unsigned       OFFSET_W   = $clog2(CACHE_LINE_WIDTH / 8);
   localparam int unsigned       BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [31:0]       ALIGN_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                      state;
   logic [BEAT_W-1:0]           beat;
   logic [CACHE_LINE_WIDTH-1:0] wline;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         beat        <= '0;
         wline       <= '0;
         line_rdata  <= '0;
         line_resp   <= 1'b0;
         line_error  <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
      end else begin
         line_resp  <= 1'b0;
         line_error <= 1'b0;
         unique case (state)
            IDLE: begin
               beat <= '0;
               if (line_write) begin
                  wline       <= line_wdata;
                  mem_address <= line_addr & ALIGN_MASK;
                  mem_write   <= 1'b1;
                  state       <= WRITE;
               end else if (line_read) begin
                  mem_address <= line_addr & ALIGN_MASK;
                  mem_read    <= 1'b1;
                  state       <= READ;
               end
            end
            READ: begin
               // an error abort wins over a beat arriving on the same edge
               if (pm_error) begin
                  mem_read   <= 1'b0;
                  line_error <= 1'b1;
                  state      <= IDLE;
               end else if (mem_resp) begin
                  line_rdata[BURST_WIDTH*int'(beat) +: BURST_WIDTH] <= mem_rdata;
                  if (beat == LAST_BEAT) begin
                     mem_read  <= 1'b0;
                     line_resp <= 1'b1;
                     state     <= DONE;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (pm_error) begin
                  mem_write  <= 1'b0;
                  line_error <= 1'b1;
                  state      <= IDLE;
               end else if (mem_resp) begin
                  if (beat == LAST_BEAT) begin
                     mem_write <= 1'b0;
                     line_resp <= 1'b1;
                     state     <= DONE;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      busy            = (state != IDLE);
      mem_wdata       = wline[BURST_WIDTH*int'(beat) +: BURST_WIDTH];
      mem_byte_enable = mem_write ? '1 : '0;
   end

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: a behavioural line memory serves bursts,
// table vectors and randomized transactions are checked against a reference line store.
module tb_cacheline_burst_adapter;

   localparam int unsigned LW = 256;
   localparam int unsigned BL = 4;
   localparam int unsigned BW = LW / BL;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          line_read, line_write;
   logic [31:0]   line_addr;
   logic [LW-1:0] line_wdata, line_rdata;
   logic          line_resp, line_error, busy;
   logic          mem_read, mem_write;
   logic [31:0]   mem_address;
   logic [BW-1:0] mem_wdata, mem_rdata;
   logic [BW/8-1:0] mem_byte_enable;
   logic          mem_resp;
   logic          pm_error;

   // single-beat build
   logic          line_read1, line_write1, line_resp1, line_error1, busy1;
   logic [31:0]   line_addr1, mem_address1;
   logic [63:0]   line_wdata1, line_rdata1, mem_wdata1, mem_rdata1;
   logic          mem_read1, mem_write1, mem_resp1, pm_error1;
   logic [7:0]    mem_byte_enable1;

   always #5 clk = ~clk;

   cacheline_burst_adapter #(.CACHE_LINE_WIDTH(LW), .BURST_LEN(BL), .BURST_WIDTH(BW)) dut (
      .clk(clk), .rst_n(rst_n), .line_read(line_read), .line_write(line_write),
      .line_addr(line_addr), .line_wdata(line_wdata), .line_rdata(line_rdata),
      .line_resp(line_resp), .line_error(line_error), .busy(busy),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .pm_error(pm_error));

   cacheline_burst_adapter #(.CACHE_LINE_WIDTH(64), .BURST_LEN(1), .BURST_WIDTH(64)) dut1 (
      .clk(clk), .rst_n(rst_n), .line_read(line_read1), .line_write(line_write1),
      .line_addr(line_addr1), .line_wdata(line_wdata1), .line_rdata(line_rdata1),
      .line_resp(line_resp1), .line_error(line_error1), .busy(busy1),
      .mem_read(mem_read1), .mem_write(mem_write1), .mem_address(mem_address1),
      .mem_wdata(mem_wdata1), .mem_byte_enable(mem_byte_enable1), .mem_rdata(mem_rdata1),
      .mem_resp(mem_resp1), .pm_error(pm_error1));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int unsigned lidx(input logic [31:0] a);
      return {27'd0, a[9:5]};
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Behavioural memory: whole lines, served or filled one beat per mem_resp
   logic [LW-1:0] mem_store [32];
   logic [LW-1:0] ref_store [32];
   int unsigned   mem_delay  = 0;
   bit            mem_gaps   = 1'b0;
   bit            stray_resp = 1'b0;
   bit            resp_pat [$];
   int unsigned   wait_cnt   = 0;
   int unsigned   mbeat      = 0;
   logic [31:0]   exp_maddr  = '0;

   always @(negedge clk) begin
      bit r;
      if (!(mem_read || mem_write)) begin
         wait_cnt = 0;
         mbeat    = 0;
         mem_resp = stray_resp;
      end else begin
         check("strobe_exclusive", mem_read & mem_write, 1'b0);
         check("mem_address_held", mem_address, exp_maddr);
         check("byte_enable", mem_byte_enable, mem_write ? 8'hFF : 8'h00);
         if (wait_cnt < mem_delay) begin
            wait_cnt++;
            mem_resp = 1'b0;
         end else begin
            if (resp_pat.size() > 0) r = resp_pat.pop_front();
            else if (mem_gaps)       r = ($urandom_range(0, 2) != 0);
            else                     r = 1'b1;
            if (mbeat >= BL) r = 1'b0;
            mem_resp = r;
            if (r) begin
               if (mem_read) mem_rdata = mem_store[lidx(mem_address)][BW*mbeat +: BW];
               else          mem_store[lidx(mem_address)][BW*mbeat +: BW] = mem_wdata;
               mbeat++;
            end
         end
      end
   end

   task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [LW-1:0] wd, input logic [31:0] exp_addr,
                      input int exp_cyc, input string tag);
      int k = 1;
      int resp_cyc = 0;
      int n_resp = 0;
      exp_maddr  = exp_addr;
      line_read  = rd;
      line_write = wr;
      line_addr  = addr;
      line_wdata = wd;
      tick();
      line_read  = 1'b0;
      line_write = 1'b0;
      line_addr  = $urandom;
      line_wdata = rand_line();
      if (wr) ref_store[lidx(exp_addr)] = wd;
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_rd_strobe"}, mem_read, rd && !wr);
      check({tag, "_wr_strobe"}, mem_write, wr);
      while (busy && k < 300) begin
         if (line_resp) begin
            n_resp++;
            resp_cyc = k;
            check({tag, "_strobes_low_at_resp"}, {mem_read, mem_write}, 2'b00);
         end
         tick();
         k++;
      end
      check({tag, "_returned_idle"}, busy, 1'b0);
      check({tag, "_resp_count"}, n_resp, 1);
      check({tag, "_no_error"}, line_error, 1'b0);
      if (exp_cyc > 0) check({tag, "_resp_cycle"}, resp_cyc, exp_cyc);
      if (wr) check({tag, "_mem_line"}, mem_store[lidx(exp_addr)], ref_store[lidx(exp_addr)]);
      else    check({tag, "_rdata"}, line_rdata, ref_store[lidx(exp_addr)]);
   endtask

   typedef struct {
      bit            rd;
      bit            wr;
      logic [31:0]   addr;
      logic [LW-1:0] wd;
      int unsigned   delay;
      logic [31:0]   exp_addr;
      int            exp_cyc;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; pm_error = 1'b0;
      line_read = 1'b0; line_write = 1'b0; line_addr = '0; line_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;
      line_read1 = 1'b0; line_write1 = 1'b0; line_addr1 = '0; line_wdata1 = '0;
      mem_rdata1 = '0; mem_resp1 = 1'b0; pm_error1 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         mem_store[i] = rand_line();
         ref_store[i] = mem_store[i];
      end
      mem_store[8] = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      ref_store[8] = mem_store[8];

      vecs[0] = '{1'b1, 1'b0, 32'h0000_010C, '0, 5, 32'h0000_0100, 10};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0240,
                  {64'h4444_0000_4444_0004, 64'h3333_0000_3333_0003,
                   64'h2222_0000_2222_0002, 64'h1111_0000_1111_0001}, 1, 32'h0000_0240, 6};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_037F, rand_line(), 0, 32'h0000_0360, 5};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0240, '0, 2, 32'h0000_0240, 7};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_03FF, '0, 3, 32'h0000_03E0, 8};

      tick(); tick();
      check("rst_busy", busy, 1'b0);
      check("rst_strobes", {mem_read, mem_write}, 2'b00);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_line_rdata", line_rdata, '0);
      check("rst_resp_err", {line_resp, line_error}, 2'b00);
      check("rst_byte_enable", mem_byte_enable, 8'h00);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         mem_delay = vecs[i].delay;
         mem_gaps  = 1'b0;
         txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_addr,
             vecs[i].exp_cyc, $sformatf("vec%0d", i));
      end

      mem_delay = 0;
      resp_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      txn(1'b1, 1'b0, 32'h0000_0100, '0, 32'h0000_0100, 8, "stall");

      mem_gaps = 1'b1;
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         int unsigned op;
         a         = 32'($urandom_range(0, 32'h3FF));
         op        = $urandom_range(0, 2);
         mem_delay = $urandom_range(0, 3);
         txn(op != 1, op != 0, a, rand_line(), a & 32'hFFFF_FFE0, -1, $sformatf("rnd%0d", i));
      end
      mem_gaps = 1'b0;

      stray_resp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("stray_idle", {busy, line_resp, mem_read, mem_write}, 4'b0000);
      end
      stray_resp = 1'b0;
      tick();

      mem_delay  = 0;
      exp_maddr  = 32'h0000_0240;
      line_write = 1'b1; line_addr = 32'h0000_0240; line_wdata = rand_line();
      tick();
      line_write = 1'b0;
      check("abort_busy", busy, 1'b1);
      tick();
      pm_error = 1'b1;
      tick();
      pm_error = 1'b0;
      check("abort_error_pulse", line_error, 1'b1);
      check("abort_idle", {busy, mem_write, line_resp}, 3'b000);
      tick();
      check("abort_error_single", line_error, 1'b0);
      check("abort_no_resp", line_resp, 1'b0);
      mem_store[lidx(32'h240)] = ref_store[lidx(32'h240)];

      exp_maddr = 32'h0000_0100;
      line_read = 1'b1; line_addr = 32'h0000_0100;
      tick();
      line_read = 1'b0;
      tick();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_strobes", {mem_read, mem_write, busy}, 3'b000);
      check("midrst_mem_address", mem_address, 32'h0);
      check("midrst_rdata", line_rdata, '0);
      check("midrst_resp", line_resp, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      txn(1'b1, 1'b0, 32'h0000_0100, '0, 32'h0000_0100, 5, "after_rst");

      line_read1 = 1'b1; line_addr1 = 32'h0000_004C;
      tick();
      line_read1 = 1'b0;
      check("b1_mem_read", {mem_read1, mem_write1}, 2'b10);
      check("b1_mem_address", mem_address1, 32'h0000_0048);
      check("b1_be_read", mem_byte_enable1, 8'h00);
      tick();
      mem_resp1 = 1'b1; mem_rdata1 = 64'h0123_4567_89AB_CDEF;
      tick();
      mem_resp1 = 1'b0; mem_rdata1 = '0;
      check("b1_resp", {line_resp1, mem_read1, busy1}, 3'b101);
      check("b1_rdata", line_rdata1, 64'h0123_4567_89AB_CDEF);
      tick();
      check("b1_idle", {busy1, line_resp1, line_error1}, 3'b000);
      line_write1 = 1'b1; line_wdata1 = 64'hFEED_FACE_CAFE_BEEF; line_addr1 = 32'h0000_0010;
      tick();
      line_write1 = 1'b0; line_wdata1 = '0;
      check("b1_wdata", mem_wdata1, 64'hFEED_FACE_CAFE_BEEF);
      check("b1_be_write", {mem_write1, mem_byte_enable1}, 9'h1FF);
      mem_resp1 = 1'b1;
      tick();
      mem_resp1 = 1'b0;
      check("b1_wresp", {line_resp1, mem_write1}, 2'b10);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cacheline_burst_adapter.md
# cacheline_burst_adapter

Sits between the L1 cache controller and the parameterised main-memory model on the multicycle OTTER. Turns a single whole-line read or write request from the cache into a burst of `BURST_LEN` beats on the memory bus, and reassembles or serialises line data as needed. Holds the memory-side request and address stable for the whole burst, which the memory model's protocol checks require. Returns one completion pulse per line transaction.

## Interface
- `CACHE_LINE_WIDTH`, 256: line size in bits.
- `BURST_LEN`, 4: beats per line; must divide `CACHE_LINE_WIDTH`; 1 is legal.
- `BURST_WIDTH`, `CACHE_LINE_WIDTH/BURST_LEN`: beat width in bits; must be a multiple of 8.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `line_read`  in  1: cache requests a line fill; sampled only in IDLE.
- `line_write`  in  1: cache requests a line writeback; sampled only in IDLE.
- `line_addr`  in  32: byte address of the line; low `$clog2(CACHE_LINE_WIDTH/8)` bits are ignored.
- `line_wdata`  in  `CACHE_LINE_WIDTH`: writeback data; captured at request acceptance.
- `line_rdata`  out  `CACHE_LINE_WIDTH`: assembled fill data; holds until the next read completes.
- `line_resp`  out  1: one-cycle completion pulse.
- `line_error`  out  1: one-cycle pulse when a transfer is aborted by `pm_error`.
- `busy`  out  1: high in every state except IDLE.
- `mem_read`, `mem_write`  out  1 each: memory-bus request strobes; never both high.
- `mem_address`  out  32: line-aligned address.
- `mem_wdata`  out  `BURST_WIDTH`: current write beat.
- `mem_byte_enable`  out  `BURST_WIDTH/8`: all ones whenever `mem_write` is high, 0 otherwise.
- `mem_rdata`  in  `BURST_WIDTH`: read beat; valid while `mem_resp` is high.
- `mem_resp`  in  1: beat handshake from memory.
- `pm_error`  in  1: memory protocol error flag.

## Operation
- **States:**
  - IDLE: `line_write` has priority. If `line_write` is high, latch the address (aligned) and `line_wdata`, then go to WRITE. Otherwise, if `line_read` is high, latch the aligned address and go to READ.
  - READ: `mem_read`=1. Each edge with `mem_resp`=1 writes `mem_rdata` into `line_rdata[BURST_WIDTH*beat +: BURST_WIDTH]` and increments `beat`. On the edge that captures beat `BURST_LEN-1`, go to DONE.
  - WRITE: `mem_write`=1 and `mem_wdata` = latched line slice `[BURST_WIDTH*beat +: BURST_WIDTH]` (combinational from `beat`). Each edge with `mem_resp`=1 increments `beat`. On the edge with `mem_resp`=1 at beat `BURST_LEN-1`, go to DONE.
  - DONE: `line_resp`=1 for exactly one cycle, `mem_read`/`mem_write`=0, then go to IDLE.
- **Beat counter:** `beat` is `max(1,$clog2(BURST_LEN))` bits wide and is cleared on entry to READ or WRITE. No wrap occurs within a transfer because the state exits at the last beat.
- **Registered strobes:** `mem_read`, `mem_write` and `mem_address` are registered. They drop on the same edge that captures or sends the final beat, so memory never sees a request on the following edge.
- **Error abort:** `pm_error`=1 in READ or WRITE forces IDLE on the next edge. The strobes drop, `line_error` pulses for one cycle, `line_resp` is not asserted, and `line_rdata` is left partially updated (undefined contents).
- **Stray handshake:** `mem_resp` while in IDLE or DONE is ignored.
- **Reset:** `rst_n` low, including mid-burst, immediately clears state to IDLE, `beat`=0, `mem_read`=`mem_write`=0, `mem_address`=0, `line_resp`=`line_error`=0, `busy`=0, `line_rdata`=0. No partial beat is committed.

## Timing
- **Request acceptance:** a request sampled at edge E0 gives `mem_read`/`mem_write` high after E0.
- **Read beats:** beat *i* is captured at the edge that ends the *i*-th cycle with `mem_resp`=1. Back-to-back `mem_resp` cycles give one beat per cycle. Gaps in `mem_resp` are tolerated and stall `beat`.
- **Write beats:** `mem_wdata` for beat *i* is valid throughout every cycle in which `beat`==*i*, including the cycle `mem_resp` first rises for that beat.
- **Completion:** `line_resp` is high in the cycle after the final-beat edge. The earliest new request is accepted one cycle later, in IDLE.
- **Minimum turnaround:** 1 (issue) + memory delay + `BURST_LEN` + 1 (DONE) + 1 (IDLE) cycles.
- **Request stability:** `line_*` inputs may change freely while `busy`=1.

## Test plan
- **Read fill:** memory line at 0x100 = 256'h…_DDDD_CCCC_BBBB_AAAA in 64-bit beats, delay 5; pulse `line_read`, `line_addr`=0x10C -> `mem_address`=0x100 held for the whole burst; `line_rdata` equals the line exactly; one `line_resp` pulse; `mem_read` low on the edge after beat 3.
- **Writeback:** `line_write` at 0x240 with 4 distinct beats -> memory contents match `line_wdata`; `mem_byte_enable`=8'hFF throughout; no `pm_error`.
- **Simultaneous requests:** `line_read`=`line_write`=1 -> a write is performed, no read issued.
- **Stalled handshake:** `mem_resp` pattern 1,0,0,1,1,0,1 -> 4 beats captured in order, `line_resp` after the 7th cycle.
- **Reset mid-burst:** `rst_n` low after 2 read beats -> outputs zero asynchronously; a new read after release completes correctly.
- **Error abort:** `pm_error` pulsed during WRITE -> `line_error` pulse, no `line_resp`, `busy`=0 next cycle; `BURST_LEN`=1 build passes the read-fill test.
